// File: rtl/lc3b_types.sv
// Shared line/address types, the arbiter state encoding and the latched
// downstream request record used by mem_arbiter and arb_req_reg.
package lc3b_types;

  typedef logic [11:0]  lc3b_wb_adr;
  typedef logic [127:0] lc3b_line;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [15:0]  lc3b_mem_sel;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    lc3b_wb_adr  addr;
    lc3b_c_line  wdata;
    lc3b_mem_sel sel;
  } arb_req_t;

  // Data-port request record; a simultaneous read+write is issued as a write.
  function automatic arb_req_t data_req(input logic rd, input logic wr,
                                        input lc3b_wb_adr addr,
                                        input lc3b_c_line wdata,
                                        input lc3b_mem_sel sel);
    arb_req_t r;
    r.rd    = rd & ~wr;
    r.wr    = wr;
    r.addr  = addr;
    r.wdata = wdata;
    r.sel   = sel;
    return r;
  endfunction

  function automatic arb_req_t ifetch_req(input lc3b_wb_adr addr);
    arb_req_t r;
    r.rd    = 1'b1;
    r.wr    = 1'b0;
    r.addr  = addr;
    r.wdata = '0;
    r.sel   = '0;
    return r;
  endfunction

endpackage

// File: rtl/arb_req_reg.sv
// Holds the downstream request captured when a grant is taken; the
// read/write strobes drop when the transaction completes.
module arb_req_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load_i,
  input  logic     clear_i,
  input  arb_req_t req_i,
  output arb_req_t req_o
);

  arb_req_t req_q, req_d;

  always_comb begin
    req_d = req_q;
    if (load_i) begin
      req_d = req_i;
    end else if (clear_i) begin
      req_d.rd = 1'b0;
      req_d.wr = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= '0;
    else        req_q <= req_d;
  end

  assign req_o = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (instruction/data) arbiter onto one line-wide memory port.
// Data wins by default; a starvation counter forces an ifetch grant.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifetch_read,
  input  lc3b_wb_adr  ifetch_address,
  output lc3b_line    ifetch_rdata,
  output logic        ifetch_resp,
  input  logic        mem_read,
  input  logic        mem_write,
  input  lc3b_wb_adr  mem_address,
  input  lc3b_c_line  mem_wdata,
  input  logic [15:0] mem_sel,
  output lc3b_line    mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [11:0] pmem_address,
  output logic [127:0] pmem_wdata,
  output logic [15:0] pmem_sel,
  input  logic [127:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          load, clear, data_pend;
  arb_req_t      req_sel, req_q;

  assign data_pend = mem_read | mem_write;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    load     = 1'b0;
    clear    = 1'b0;
    req_sel  = data_req(mem_read, mem_write, mem_address, mem_wdata, mem_sel);
    case (state_q)
      IDLE: begin
        if (data_pend && (starve_q < LIMIT_C || !ifetch_read)) begin
          state_d = GRANT_D;
          load    = 1'b1;
          if (!ifetch_read)           starve_d = '0;
          else if (starve_q < LIMIT_C) starve_d = starve_q + CW'(1);
        end else if (ifetch_read) begin
          state_d  = GRANT_I;
          load     = 1'b1;
          req_sel  = ifetch_req(ifetch_address);
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      GRANT_D, GRANT_I: begin
        // Client inputs are ignored here; the latched request stays on pmem.
        if (pmem_resp) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  arb_req_reg u_req (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .clear_i(clear),
    .req_i  (req_sel),
    .req_o  (req_q)
  );

  assign pmem_read    = req_q.rd;
  assign pmem_write   = req_q.wr;
  assign pmem_address = req_q.addr;
  assign pmem_wdata   = req_q.wdata;
  assign pmem_sel     = req_q.sel;

  assign mem_resp     = (state_q == GRANT_D) & pmem_resp;
  assign ifetch_resp  = (state_q == GRANT_I) & pmem_resp;
  assign mem_rdata    = pmem_rdata;
  assign ifetch_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard of expected
// client responses, and hand sequences for hold, starvation and reset abort.
module tb_mem_arbiter;
  import lc3b_types::*;

  localparam int SL = 4;

  logic        clk, rst_n;
  logic        ifetch_read;
  lc3b_wb_adr  ifetch_address;
  lc3b_line    ifetch_rdata;
  logic        ifetch_resp;
  logic        mem_read, mem_write;
  lc3b_wb_adr  mem_address;
  lc3b_c_line  mem_wdata;
  logic [15:0] mem_sel;
  lc3b_line    mem_rdata;
  logic        mem_resp;
  logic        pmem_read, pmem_write;
  logic [11:0] pmem_address;
  logic [127:0] pmem_wdata;
  logic [15:0] pmem_sel;
  logic [127:0] pmem_rdata;
  logic        pmem_resp;

  mem_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifetch_read(ifetch_read), .ifetch_address(ifetch_address),
    .ifetch_rdata(ifetch_rdata), .ifetch_resp(ifetch_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_sel(pmem_sel), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic     is_d;
    lc3b_line data;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        ird, mrd, mwr;
    lc3b_wb_adr  iadr, madr;
    logic [15:0] sel;
    lc3b_c_line  wd;
    logic        exp_d, exp_rd, exp_wr;
    lc3b_wb_adr  exp_adr;
  } vec_t;
  vec_t vt[6];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Pops the scoreboard whenever either client sees a completion pulse.
  task automatic mon();
    sb_t e;
    if (mem_resp || ifetch_resp) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp got mem=%0b if=%0b want none", mem_resp, ifetch_resp);
      end else begin
        e = sbq.pop_front();
        chk("resp_mem", 128'(mem_resp), 128'(e.is_d));
        chk("resp_if", 128'(ifetch_resp), 128'(!e.is_d));
        chk("rdata", e.is_d ? mem_rdata : ifetch_rdata, e.data);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    #1;
    mon();
  endtask

  task automatic wait_req(input string nm, output int lat);
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (pmem_read || pmem_write) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no pmem request want request within 8 cycles", nm);
    end
  endtask

  task automatic respond(input logic is_d, input lc3b_line d);
    pmem_rdata = d;
    pmem_resp  = 1'b1;
    sbq.push_back('{is_d, d});
    #1;
    mon();
    cycle();
    pmem_resp = 1'b0;
    chk("resp_seen", 128'(sbq.size()), 128'(0));
    chk("req_drop", {126'd0, pmem_read, pmem_write}, 128'd0);
  endtask

  initial begin
    int lat;
    int cnt;
    logic ed;

    vt[0] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h0A3, 16'h0000, 128'h0,
              1'b1, 1'b1, 1'b0, 12'h0A3};
    vt[1] = '{1'b1, 1'b0, 1'b1, 12'h040, 12'h120, 16'h0003, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555,
              1'b1, 1'b0, 1'b1, 12'h120};
    vt[2] = '{1'b1, 1'b0, 1'b0, 12'h040, 12'h120, 16'h0000, 128'h0,
              1'b0, 1'b1, 1'b0, 12'h040};
    vt[3] = '{1'b0, 1'b1, 1'b1, 12'h000, 12'h055, 16'hFFFF, 128'hA5A5_A5A5_5A5A_5A5A_F0F0_F0F0_0F0F_0F0F,
              1'b1, 1'b0, 1'b1, 12'h055};
    vt[4] = '{1'b1, 1'b0, 1'b0, 12'h3C4, 12'h000, 16'h0000, 128'h0,
              1'b0, 1'b1, 1'b0, 12'h3C4};
    vt[5] = '{1'b0, 1'b0, 1'b1, 12'h000, 12'hFFF, 16'h8000, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
              1'b1, 1'b0, 1'b1, 12'hFFF};

    rst_n = 1'b0;
    ifetch_read = 1'b0; ifetch_address = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_wdata = '0; mem_sel = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    cycle();
    cycle();
    chk("rst_pmem_rw", {126'd0, pmem_read, pmem_write}, 128'd0);
    chk("rst_resp", {126'd0, mem_resp, ifetch_resp}, 128'd0);
    chk("rst_addr", 128'(pmem_address), 128'd0);
    chk("rst_wdata", pmem_wdata, 128'd0);
    chk("rst_sel", 128'(pmem_sel), 128'd0);
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 6; i++) begin
      ifetch_read    = vt[i].ird;
      ifetch_address = vt[i].iadr;
      mem_read       = vt[i].mrd;
      mem_write      = vt[i].mwr;
      mem_address    = vt[i].madr;
      mem_wdata      = vt[i].wd;
      mem_sel        = vt[i].sel;
      wait_req("vec", lat);
      chk("vec_latency", 128'(lat), 128'(0));
      chk("vec_rd", 128'(pmem_read), 128'(vt[i].exp_rd));
      chk("vec_wr", 128'(pmem_write), 128'(vt[i].exp_wr));
      chk("vec_addr", 128'(pmem_address), 128'(vt[i].exp_adr));
      if (vt[i].exp_wr) begin
        chk("vec_sel", 128'(pmem_sel), 128'(vt[i].sel));
        chk("vec_wdata", pmem_wdata, vt[i].wd);
      end
      respond(vt[i].exp_d, (i == 0) ? 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978
                                    : {4{32'hC0DE_0000 + 32'(i)}});
      if (vt[i].exp_d) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end else begin
        ifetch_read = 1'b0;
      end
    end

    // Latched address must survive client address changes mid-grant.
    ifetch_read = 1'b1;
    ifetch_address = 12'h010;
    wait_req("hold", lat);
    ifetch_address = 12'hFFF;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold_addr", 128'(pmem_address), 128'(12'h010));
      chk("hold_rd", 128'(pmem_read), 128'd1);
    end
    respond(1'b0, 128'h0000_1111_2222_3333_4444_5555_6666_7777);
    ifetch_read = 1'b0;
    cycle();

    // Both clients held: expect SL data grants then one ifetch grant, repeating.
    ifetch_address = 12'h200;
    mem_address    = 12'h300;
    ifetch_read    = 1'b1;
    mem_read       = 1'b1;
    cnt = 0;
    for (int g = 0; g < 2 * (SL + 1); g++) begin
      wait_req("starve", lat);
      ed = (cnt < SL);
      if (ed) cnt++;
      else    cnt = 0;
      chk("starve_grant", 128'(pmem_address), ed ? 128'(12'h300) : 128'(12'h200));
      respond(ed, {8{16'(g)}});
    end
    ifetch_read = 1'b0;
    mem_read    = 1'b0;
    cycle();

    // Reset mid-grant aborts; a stray completion afterward is ignored.
    mem_read    = 1'b1;
    mem_address = 12'h0A0;
    wait_req("rstab", lat);
    cycle();
    chk("rstab_pre", 128'(pmem_read), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("rstab_rd", 128'(pmem_read), 128'd0);
    chk("rstab_addr", 128'(pmem_address), 128'd0);
    mem_read = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    pmem_rdata = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    pmem_resp  = 1'b1;
    #1;
    chk("stray_resp", {126'd0, mem_resp, ifetch_resp}, 128'd0);
    cycle();
    pmem_resp = 1'b0;
    cycle();
    chk("stray_idle", {126'd0, pmem_read, pmem_write}, 128'd0);

    chk("sb_final", 128'(sbq.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while ifetch is pending before ifetch is forced a grant.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ifetch_read  input  1  instruction-port read request, held until ifetch_resp.
REQ-005 ifetch_address  input  lc3b_wb_adr (12)  instruction line address (word address bits [15:4]).
REQ-006 ifetch_rdata  output  lc3b_line (128)  instruction line data.
REQ-007 ifetch_resp  output  1  one-cycle completion pulse to instruction port.
REQ-008 mem_read, mem_write  input  1 each  data-port requests, held until mem_resp.
REQ-009 mem_address  input  lc3b_wb_adr (12)  data line address.
REQ-010 mem_wdata  input  lc3b_c_line (128)  data write line.
REQ-011 mem_sel  input  16  byte-lane select for writes.
REQ-012 mem_rdata  output  lc3b_line (128)  data read line.
REQ-013 mem_resp  output  1  one-cycle completion pulse to data port.
REQ-014 pmem_read, pmem_write  output  1 each  downstream requests.
REQ-015 pmem_address  output  12  downstream line address; pmem_wdata  output  128; pmem_sel  output  16.
REQ-016 pmem_rdata  input  128; pmem_resp  input  1  downstream data and completion.

Function
REQ-017 The FSM SHALL have states IDLE, GRANT_D, GRANT_I.
REQ-018 In IDLE, the request SHALL be sampled: data pending and (starve_cnt < STARVE_LIMIT or ifetch idle) -> GRANT_D; else ifetch pending -> GRANT_I; else stay IDLE.
REQ-019 On entering a grant state, address, wdata, sel and read/write type SHALL be latched into registers; pmem_* SHALL be driven only from these registers, asserted from the cycle after sampling.
REQ-020 The grant state SHALL hold pmem_read/pmem_write steady until pmem_resp, regardless of client input changes.
REQ-021 On pmem_resp, the granted client's resp SHALL pulse in that same cycle, with rdata passed combinationally from pmem_rdata; the FSM SHALL return to IDLE next cycle; pmem requests SHALL deassert in that next cycle.
REQ-022 The non-granted client's resp SHALL remain 0; its rdata value is don't-care.
REQ-023 Minimum transaction turnaround: sample (IDLE) -> pmem request -> resp -> IDLE; at least one IDLE cycle SHALL separate grants.
REQ-024 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment on each GRANT_D entry while ifetch_read=1, saturate at STARVE_LIMIT, and clear on GRANT_I entry or on any IDLE sample with ifetch_read=0.
REQ-025 If mem_read and mem_write are both 1, the arbiter SHALL perform a write only.
REQ-026 pmem_resp arriving in IDLE SHALL be ignored; no client resp SHALL be generated.

Reset
REQ-027 While rst_n=0: state=IDLE; starve_cnt=0; pmem_read=pmem_write=0; ifetch_resp=mem_resp=0; latched address/wdata/sel=0.
REQ-028 Reset asserted mid-transaction SHALL abort the grant immediately; a pmem_resp after release SHALL be ignored per REQ-026.

Structure
REQ-029 The arbiter state enum and lc3b_line/lc3b_c_line/lc3b_wb_adr types SHALL reside in lc3b_types; STARVE_LIMIT SHALL remain a module parameter.
REQ-030 One sub-module, arb_req_reg, SHALL hold the latched downstream request (address, wdata, sel, type); the FSM and counter SHALL live in mem_arbiter.

Verification
REQ-031 Data-only read: mem_read=1, mem_address=12'h0A3; pmem_read=1 with pmem_address=12'h0A3 next cycle; pmem_resp with rdata=128'h1234... -> mem_resp=1 with mem_rdata equal, ifetch_resp=0.
REQ-032 Simultaneous ifetch_read and mem_write (sel=16'h0003): data granted first with pmem_write=1, pmem_sel=16'h0003; ifetch then granted after one IDLE cycle.
REQ-033 Starvation: ifetch_read and mem_read held high continuously with STARVE_LIMIT=4 -> four GRANT_D, then one GRANT_I, counter cleared, pattern repeats.
REQ-034 Client address changes to 12'hFFF during GRANT_I -> pmem_address stays at originally latched 12'h010 until pmem_resp.
REQ-035 rst_n low while GRANT_D awaits resp -> pmem_read=0 immediately; after release, stray pmem_resp produces no mem_resp/ifetch_resp.
REQ-036 mem_read=mem_write=1 -> only pmem_write=1, pmem_read=0.
